// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and types.
//   DATA_W : default per-channel pixel width
//   KSIZE  : convolution kernel edge length
//   NCH    : number of colour channels carried side by side
//   win_state_e : window generator state (FILL until 4 full rows exist)
package cnn_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned KSIZE  = 5;
    localparam int unsigned NCH    = 3;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image-row delay: a DEPTH-deep RAM, read and written at the same address.
// The read is combinational and returns the old word, so dout at column c is
// the word written one row earlier at column c. No reset on the storage.
//   clk  : clock
//   we   : write enable (one accepted pixel)
//   addr : column address
//   din  : word to store
//   dout : word stored at addr on the previous row
module line_buffer #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_3ch_5x5.sv
// 5x5 sliding-window generator for 3-channel raster video.
// Four chained line buffers supply the previous rows; a per-channel 5x5
// register window shifts left once per accepted pixel. A window is emitted
// (latency 1) only when it lies fully inside the current frame.
//   clk, rst      : clock, asynchronous active-high reset
//   valid_in      : qualifies pix_in / sof_in
//   sof_in        : pixel is row 0, column 0
//   pix_in        : {ch0, ch1, ch2}
//   ch0/1/2_flat  : 5x5 window, element r*5+c at [(25-i)*DATA_W-1 -: DATA_W]
//   valid_out     : window outputs are valid this cycle
//   frame_done    : last window of the frame
module conv_window_3ch_5x5
    import cnn_pkg::KSIZE, cnn_pkg::NCH, cnn_pkg::win_state_e, cnn_pkg::FILL, cnn_pkg::STREAM;
#(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_in,
    input  logic                            sof_in,
    input  logic [NCH*DATA_W-1:0]           pix_in,
    output logic [DATA_W*KSIZE*KSIZE-1:0]   ch0_flat,
    output logic [DATA_W*KSIZE*KSIZE-1:0]   ch1_flat,
    output logic [DATA_W*KSIZE*KSIZE-1:0]   ch2_flat,
    output logic                            valid_out,
    output logic                            frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned LB_N  = KSIZE - 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(KSIZE - 1);

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    win_state_e       state_q, state_d, cur_state;
    logic             emit, emit_last;
    logic             valid_q, done_q;

    logic [NCH*DATA_W-1:0] lb_din  [LB_N];
    logic [NCH*DATA_W-1:0] lb_dout [LB_N];
    logic [NCH*DATA_W-1:0] tap     [KSIZE];
    logic [DATA_W-1:0]     win_q   [NCH][KSIZE][KSIZE];
    logic [NCH-1:0][DATA_W*KSIZE*KSIZE-1:0] flat;

    // An accepted sof overrides the counters (and any wrap) for this pixel.
    always_comb begin
        cur_col   = sof_in ? '0 : col_q;
        cur_row   = sof_in ? '0 : row_q;
        cur_state = sof_in ? FILL : state_q;
        col_d     = col_q;
        row_d     = row_q;
        if (valid_in) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Next state follows the row of the next pixel; covers row wrap and sof.
    always_comb begin
        state_d = state_q;
        if (valid_in) begin
            state_d = (row_d >= ROW_MIN) ? STREAM : FILL;
        end
    end

    // Columns 0..3 of every row only refill the window.
    always_comb begin
        emit      = valid_in && (cur_state == STREAM) && (cur_col >= COL_MIN);
        emit_last = emit && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= emit;
            done_q  <= emit_last;
        end
    end

    for (genvar k = 0; k < LB_N; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_din[k] = pix_in;
        end else begin : g_tail
            assign lb_din[k] = lb_dout[k-1];
        end
        line_buffer #(
            .WIDTH (NCH * DATA_W),
            .DEPTH (IMG_W)
        ) u_line_buffer (
            .clk  (clk),
            .we   (valid_in),
            .addr (cur_col),
            .din  (lb_din[k]),
            .dout (lb_dout[k])
        );
    end

    // New window column, top to bottom: rows row-4 .. row-1, then the live pixel.
    always_comb begin
        for (int r = 0; r < int'(LB_N); r++) begin
            tap[r] = lb_dout[LB_N-1-r];
        end
        tap[KSIZE-1] = pix_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < int'(NCH); ch++) begin
                for (int r = 0; r < int'(KSIZE); r++) begin
                    for (int c = 0; c < int'(KSIZE); c++) begin
                        win_q[ch][r][c] <= '0;
                    end
                end
            end
        end else if (valid_in) begin
            for (int ch = 0; ch < int'(NCH); ch++) begin
                for (int r = 0; r < int'(KSIZE); r++) begin
                    for (int c = 0; c < int'(KSIZE) - 1; c++) begin
                        win_q[ch][r][c] <= win_q[ch][r][c+1];
                    end
                    win_q[ch][r][KSIZE-1] <= tap[r][(int'(NCH) - ch)*int'(DATA_W) - 1 -: DATA_W];
                end
            end
        end
    end

    always_comb begin
        flat = '0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            for (int r = 0; r < int'(KSIZE); r++) begin
                for (int c = 0; c < int'(KSIZE); c++) begin
                    flat[ch][(int'(KSIZE*KSIZE) - (r*int'(KSIZE) + c))*int'(DATA_W) - 1 -: DATA_W] =
                        win_q[ch][r][c];
                end
            end
        end
    end

    assign ch0_flat   = flat[0];
    assign ch1_flat   = flat[1];
    assign ch2_flat   = flat[2];
    assign valid_out  = valid_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_conv_window_3ch_5x5.sv
module tb_conv_window_3ch_5x5;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int FW = DW * 25;

    typedef struct {
        logic [FW-1:0] f0;
        logic [FW-1:0] f1;
        logic [FW-1:0] f2;
        logic          last;
    } win_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          sof_in = 1'b0;
    logic [3*DW-1:0] pix_in = '0;
    logic [FW-1:0] ch0_flat, ch1_flat, ch2_flat;
    logic          valid_out, frame_done;

    win_t sb_q[$];
    int   n_checks = 0;
    int   n_bad = 0;
    int   win_cnt = 0;
    int   done_cnt = 0;
    int   pos_r = 0;
    int   pos_c = 0;

    conv_window_3ch_5x5 #(
        .DATA_W (DW),
        .IMG_W  (IW),
        .IMG_H  (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .sof_in     (sof_in),
        .pix_in     (pix_in),
        .ch0_flat   (ch0_flat),
        .ch1_flat   (ch1_flat),
        .ch2_flat   (ch2_flat),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [FW-1:0] got,
                               input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pval(input int k, input int r, input int c,
                                           input int ofs);
        return DW'(r * IW + c + ofs + 64 * k);
    endfunction

    function automatic logic [FW-1:0] exp_flat(input int k, input int r, input int c,
                                               input int ofs);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < 25; i++) begin
            f[(25 - i) * DW - 1 -: DW] = pval(k, r - 4 + i / 5, c - 4 + i % 5, ofs);
        end
        return f;
    endfunction

    // Checks outputs one step after the active edge; pops the scoreboard on a window.
    task automatic check_output(input bit exp_v);
        win_t w;
        check_value("valid_out", FW'(valid_out), FW'(exp_v));
        if (valid_out) win_cnt++;
        if (frame_done) done_cnt++;
        if (exp_v && sb_q.size() > 0) begin
            w = sb_q.pop_front();
            check_value("ch0_flat", ch0_flat, w.f0);
            check_value("ch1_flat", ch1_flat, w.f1);
            check_value("ch2_flat", ch2_flat, w.f2);
            check_value("frame_done", FW'(frame_done), FW'(w.last));
        end else begin
            check_value("frame_done_idle", FW'(frame_done), '0);
        end
    endtask

    task automatic push_pixel(input bit sof, input int ofs);
        win_t w;
        bit   exp_v;
        if (sof) begin
            pos_r = 0;
            pos_c = 0;
        end
        valid_in = 1'b1;
        sof_in   = sof;
        pix_in   = {pval(0, pos_r, pos_c, ofs), pval(1, pos_r, pos_c, ofs),
                    pval(2, pos_r, pos_c, ofs)};
        exp_v = (pos_r >= 4) && (pos_c >= 4);
        if (exp_v) begin
            w.f0   = exp_flat(0, pos_r, pos_c, ofs);
            w.f1   = exp_flat(1, pos_r, pos_c, ofs);
            w.f2   = exp_flat(2, pos_r, pos_c, ofs);
            w.last = (pos_r == IH - 1) && (pos_c == IW - 1);
            sb_q.push_back(w);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        check_output(exp_v);
        if (pos_c == IW - 1) begin
            pos_c = 0;
            pos_r = (pos_r == IH - 1) ? 0 : pos_r + 1;
        end else begin
            pos_c++;
        end
    endtask

    // Idle cycle; a stray sof_in without valid_in must be ignored.
    task automatic idle_cycle(input bit stray_sof);
        valid_in = 1'b0;
        sof_in   = stray_sof;
        pix_in   = 24'hA5A5A5;
        @(posedge clk);
        #1;
        sof_in = 1'b0;
        check_output(1'b0);
    endtask

    task automatic send_frame(input bit sof, input int ofs, input bit gaps);
        for (int p = 0; p < IW * IH; p++) begin
            push_pixel(sof && (p == 0), ofs);
            if (gaps) idle_cycle(p[0]);
        end
    endtask

    task automatic start_count();
        win_cnt  = 0;
        done_cnt = 0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_valid", FW'(valid_out), '0);
        check_value("rst_done", FW'(frame_done), '0);
        check_value("rst_ch0", ch0_flat, '0);
        check_value("rst_ch2", ch2_flat, '0);
        rst = 1'b0;
        idle_cycle(1'b0);

        // Continuous frame
        start_count();
        send_frame(1'b1, 0, 1'b0);
        check_value("cont_wins", FW'(win_cnt), FW'(16));
        check_value("cont_done", FW'(done_cnt), FW'(1));

        // Same frame with an idle cycle after every pixel
        start_count();
        send_frame(1'b1, 0, 1'b1);
        check_value("gap_wins", FW'(win_cnt), FW'(16));
        check_value("gap_done", FW'(done_cnt), FW'(1));

        // Reset after pixel 40, restart without sof
        for (int p = 0; p <= 40; p++) push_pixel(p == 0, 0);
        rst = 1'b1;
        #1;
        check_value("mid_rst_valid", FW'(valid_out), '0);
        check_value("mid_rst_ch0", ch0_flat, '0);
        check_value("mid_rst_ch1", ch1_flat, '0);
        @(posedge clk);
        #1;
        check_value("mid_rst_done", FW'(frame_done), '0);
        rst = 1'b0;
        sb_q.delete();
        pos_r = 0;
        pos_c = 0;
        start_count();
        send_frame(1'b0, 0, 1'b0);
        check_value("rst_wins", FW'(win_cnt), FW'(16));
        check_value("rst_fdone", FW'(done_cnt), FW'(1));

        // Partial frame, resync with sof on pixel 20
        for (int p = 0; p < 20; p++) push_pixel(1'b0, 0);
        start_count();
        send_frame(1'b1, 0, 1'b0);
        check_value("sync_wins", FW'(win_cnt), FW'(16));
        check_value("sync_done", FW'(done_cnt), FW'(1));

        // Resync from inside the streaming rows, new frame data differs
        send_frame(1'b1, 0, 1'b0);
        for (int p = 0; p < 45; p++) push_pixel(1'b0, 3);
        start_count();
        send_frame(1'b1, 9, 1'b0);
        check_value("sync2_wins", FW'(win_cnt), FW'(16));

        // Back-to-back frames, second one via wrap only
        start_count();
        send_frame(1'b1, 0, 1'b0);
        send_frame(1'b0, 0, 1'b0);
        check_value("b2b_wins", FW'(win_cnt), FW'(32));
        check_value("b2b_done", FW'(done_cnt), FW'(2));

        // Back-to-back with different data; sof coincides with the wrap
        start_count();
        send_frame(1'b1, 0, 1'b0);
        send_frame(1'b1, 100, 1'b0);
        check_value("b2b2_wins", FW'(win_cnt), FW'(32));
        check_value("b2b2_done", FW'(done_cnt), FW'(2));

        idle_cycle(1'b0);
        check_value("sb_drained", FW'(sb_q.size()), '0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
